// File: rtl/clock_cycle_sequencer.sv
// Interrogation-cycle phase sequencer: COOL -> PREP -> PULSE1 -> DARK -> PULSE2 -> DETECT,
// repeated n_cycles times (0 = continuous), holding expired phases while ann_busy is high.
module clock_cycle_sequencer #(
   parameter int TW     = 16,
   parameter int CW     = 16,
   parameter int T_COOL = 1000,
   parameter int T_PREP = 100,
   parameter int T_P1   = 20,
   parameter int T_DARK = 500,
   parameter int T_P2   = 20,
   parameter int T_DET  = 200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] n_cycles,
   input  logic          ann_busy,
   output logic [2:0]    state,
   output logic          state_change,
   output logic          cycle_done,
   output logic          run_active,
   output logic [CW-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_COOL = 3'd1,
      S_PREP = 3'd2,
      S_P1   = 3'd3,
      S_DARK = 3'd4,
      S_P2   = 3'd5,
      S_DET  = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] ncyc_q, ncyc_d;
   logic          state_change_q;
   logic          cycle_done_q, cycle_done_d;
   logic          run_active_q;

   function automatic logic [TW-1:0] load_val(input state_t s);
      case (s)
         S_COOL:  return TW'(T_COOL - 1);
         S_PREP:  return TW'(T_PREP - 1);
         S_P1:    return TW'(T_P1 - 1);
         S_DARK:  return TW'(T_DARK - 1);
         S_P2:    return TW'(T_P2 - 1);
         S_DET:   return TW'(T_DET - 1);
         default: return '0;
      endcase
   endfunction

   function automatic state_t next_phase(input state_t s);
      case (s)
         S_COOL:  return S_PREP;
         S_PREP:  return S_P1;
         S_P1:    return S_DARK;
         S_DARK:  return S_P2;
         S_P2:    return S_DET;
         default: return S_IDLE;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      count_d = count_q;
      ncyc_d  = ncyc_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_COOL;
               count_d = '0;
               ncyc_d  = n_cycles;
            end
         end
         S_COOL, S_PREP, S_P1, S_DARK, S_P2, S_DET: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else if (!ann_busy) begin
               if (state_q == S_DET) begin
                  count_d = count_q + CW'(1);
                  state_d = (ncyc_q != '0 && count_d == ncyc_q) ? S_IDLE : S_COOL;
               end else begin
                  state_d = next_phase(state_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q)
         timer_d = load_val(state_d);
   end

   // cycle_done is registered, so it is raised on the edge where DETECT's timer reaches 0.
   assign cycle_done_d = (state_d == S_DET) && (timer_d == '0) &&
                         !((state_q == S_DET) && (timer_q == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         count_q        <= '0;
         ncyc_q         <= '0;
         state_change_q <= 1'b0;
         cycle_done_q   <= 1'b0;
         run_active_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         count_q        <= count_d;
         ncyc_q         <= ncyc_d;
         state_change_q <= (state_d != state_q);
         cycle_done_q   <= cycle_done_d;
         run_active_q   <= (state_d != S_IDLE);
      end
   end

   assign state        = state_q;
   assign state_change = state_change_q;
   assign cycle_done   = cycle_done_q;
   assign run_active   = run_active_q;
   assign cycle_count  = count_q;

endmodule

// File: tb/tb_clock_cycle_sequencer.sv
// Scoreboard bench for clock_cycle_sequencer: stimulus queues expected state changes
// and cycle_done pulses with cycle stamps; a negedge monitor pops and compares them.
module tb_clock_cycle_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] n_cycles = '0;
   logic       ann_busy = 1'b0;
   logic [2:0] state;
   logic       state_change;
   logic       cycle_done;
   logic       run_active;
   logic [2:0] cycle_count;

   clock_cycle_sequencer #(
      .TW(8), .CW(3),
      .T_COOL(2), .T_PREP(3), .T_P1(1), .T_DARK(4), .T_P2(1), .T_DET(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .n_cycles(n_cycles),
      .ann_busy(ann_busy), .state(state), .state_change(state_change),
      .cycle_done(cycle_done), .run_active(run_active), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic [2:0] cnt;
   } ev_t;

   ev_t  evq[$];
   int   dq[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [2:0] exp_st = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input logic [2:0] st, input logic [2:0] cnt);
      ev_t e;
      e.cyc = c; e.st = st; e.cnt = cnt;
      evq.push_back(e);
   endtask

   // One full interrogation cycle whose COOL is entered in cycle c (13 clocks long).
   task automatic push_cycle(input int c, input logic [2:0] cnt);
      push_ev(c,      3'd1, cnt);
      push_ev(c + 2,  3'd2, cnt);
      push_ev(c + 5,  3'd3, cnt);
      push_ev(c + 6,  3'd4, cnt);
      push_ev(c + 10, 3'd5, cnt);
      push_ev(c + 11, 3'd6, cnt);
      dq.push_back(c + 12);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   // Monitor: compares every state_change / cycle_done against the queues.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_st = '0;
      end else begin
         if (state_change) begin
            if (evq.size() == 0) begin
               check("unexpected_state_change", 32'(state), 32'd8);
            end else begin
               ev_t e;
               e = evq.pop_front();
               check("change_cycle", 32'(cyc), 32'(e.cyc));
               check("change_state", 32'(state), 32'(e.st));
               check("change_count", 32'(cycle_count), 32'(e.cnt));
               exp_st = e.st;
            end
         end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
            check("missed_state_change", 32'(state_change), 32'd1);
            exp_st = evq[0].st;
            void'(evq.pop_front());
         end
         check("state_track", 32'(state), 32'(exp_st));
         check("run_active", 32'(run_active), 32'(exp_st != 3'd0));
         if (cycle_done) begin
            if (dq.size() == 0) check("unexpected_cycle_done", 32'(cycle_done), 32'd0);
            else check("cycle_done_cycle", 32'(cyc), 32'(dq.pop_front()));
         end else if (dq.size() != 0 && dq[0] <= cyc) begin
            check("missed_cycle_done", 32'(cycle_done), 32'd1);
            void'(dq.pop_front());
         end
      end
   end

   initial begin
      int k;
      tick(2);
      check("reset_state", 32'(state), 32'd0);
      check("reset_count", 32'(cycle_count), 32'd0);
      check("reset_run_active", 32'(run_active), 32'd0);
      check("reset_pulses", 32'({state_change, cycle_done}), 32'd0);
      rst = 1'b0;
      tick(3);

      // Single cycle, n_cycles=1
      k = cyc; start = 1'b1; n_cycles = 3'd1;
      push_cycle(k + 1, 3'd0);
      push_ev(k + 14, 3'd0, 3'd1);
      tick(1); start = 1'b0;
      wait_until(k + 17);
      check("single_count", 32'(cycle_count), 32'd1);

      // Three cycles
      k = cyc; start = 1'b1; n_cycles = 3'd3;
      push_cycle(k + 1, 3'd0);
      push_cycle(k + 14, 3'd1);
      push_cycle(k + 27, 3'd2);
      push_ev(k + 40, 3'd0, 3'd3);
      tick(1); start = 1'b0;
      wait_until(k + 43);
      check("three_count", 32'(cycle_count), 32'd3);

      // ann_busy before expiry (no effect), then 5-clock hold at DARK expiry
      k = cyc; start = 1'b1; n_cycles = 3'd1;
      push_ev(k + 1, 3'd1, 3'd0);
      push_ev(k + 3, 3'd2, 3'd0);
      push_ev(k + 6, 3'd3, 3'd0);
      push_ev(k + 7, 3'd4, 3'd0);
      push_ev(k + 16, 3'd5, 3'd0);
      push_ev(k + 17, 3'd6, 3'd0);
      dq.push_back(k + 18);
      push_ev(k + 19, 3'd0, 3'd1);
      tick(1); start = 1'b0; ann_busy = 1'b1;
      tick(1); ann_busy = 1'b0;
      wait_until(k + 10); ann_busy = 1'b1;
      wait_until(k + 15); ann_busy = 1'b0;
      wait_until(k + 22);

      // Abort in PULSE1 on the same cycle it expires
      k = cyc; start = 1'b1; n_cycles = 3'd2;
      push_ev(k + 1, 3'd1, 3'd0);
      push_ev(k + 3, 3'd2, 3'd0);
      push_ev(k + 6, 3'd3, 3'd0);
      push_ev(k + 7, 3'd0, 3'd0);
      tick(1); start = 1'b0;
      wait_until(k + 6); abort = 1'b1;
      tick(1); abort = 1'b0;
      wait_until(k + 10);
      check("abort_p1_count", 32'(cycle_count), 32'd0);

      // Abort mid-DARK after one completed cycle: count must hold at 1
      k = cyc; start = 1'b1; n_cycles = 3'd0;
      push_cycle(k + 1, 3'd0);
      push_ev(k + 14, 3'd1, 3'd1);
      push_ev(k + 16, 3'd2, 3'd1);
      push_ev(k + 19, 3'd3, 3'd1);
      push_ev(k + 20, 3'd4, 3'd1);
      push_ev(k + 23, 3'd0, 3'd1);
      tick(1); start = 1'b0;
      wait_until(k + 22); abort = 1'b1;
      tick(1); abort = 1'b0;
      wait_until(k + 26);
      check("abort_dark_count", 32'(cycle_count), 32'd1);

      // start together with abort in IDLE: nothing happens
      start = 1'b1; abort = 1'b1;
      tick(1); start = 1'b0; abort = 1'b0;
      tick(3);
      check("start_abort_idle", 32'(state), 32'd0);

      // Continuous run with 3-bit counter wrap; start held high and ignored while running
      k = cyc; start = 1'b1; n_cycles = 3'd0;
      for (int i = 0; i < 10; i++) push_cycle(k + 1 + 13 * i, 3'(i % 8));
      push_ev(k + 131, 3'd1, 3'd2);
      push_ev(k + 132, 3'd0, 3'd2);
      tick(1); n_cycles = 3'd1;
      wait_until(k + 131); abort = 1'b1; start = 1'b0;
      tick(1); abort = 1'b0;
      wait_until(k + 135);
      check("wrap_count", 32'(cycle_count), 32'd2);

      // Reset mid-DARK of the second cycle
      k = cyc; start = 1'b1; n_cycles = 3'd0;
      push_cycle(k + 1, 3'd0);
      push_ev(k + 14, 3'd1, 3'd1);
      push_ev(k + 16, 3'd2, 3'd1);
      push_ev(k + 19, 3'd3, 3'd1);
      push_ev(k + 20, 3'd4, 3'd1);
      tick(1); start = 1'b0;
      wait_until(k + 22);
      check("pre_reset_count", 32'(cycle_count), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_run_active", 32'(run_active), 32'd0);
      check("midrst_count", 32'(cycle_count), 32'd0);
      check("midrst_pulses", 32'({state_change, cycle_done}), 32'd0);
      tick(2); rst = 1'b0;
      tick(6);
      check("post_reset_state", 32'(state), 32'd0);

      check("events_left", 32'(evq.size()), 32'd0);
      check("done_left", 32'(dq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
